// File: rtl/rom_dump_tx.sv
// Debug readback: reads a range of instruction-ROM words and streams them MSB byte first as 8N1 UART frames.
// Optional ROM_DUMP_CHECKSUM_EN appends an 8-bit mod-256 sum of all data bytes as one extra frame.
`timescale 1ns/1ps

module rom_dump_tx #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned UART_BPS = 115200
) (
   input  logic        clk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [15:0] num_words,
   output logic        ce,
   output logic [31:0] addr_o,
   input  logic [31:0] data_i,
   output logic        uart_txd,
   output logic        busy,
   output logic        done
);

   localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int unsigned CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam int unsigned BIT_W   = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      TX_BYTE,
`ifdef ROM_DUMP_CHECKSUM_EN
      CKSUM,
`endif
      FINISH
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   clk_cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [1:0]         byte_idx;
   logic [31:0]        word_sr;
   logic [7:0]         tx_shift;
   logic [31:0]        cur_addr;
   logic [15:0]        remaining;
`ifdef ROM_DUMP_CHECKSUM_EN
   logic [7:0]         sum;
`endif

   // Frame bit index: 0 = start, 1..8 = data LSB first, 9 = stop.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         byte_idx  <= '0;
         word_sr   <= '0;
         tx_shift  <= '0;
         cur_addr  <= '0;
         remaining <= '0;
         ce        <= 1'b0;
         addr_o    <= '0;
         uart_txd  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
         sum       <= '0;
`endif
      end else begin
         ce   <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_words != 16'd0) begin
                     cur_addr  <= base_addr;
                     addr_o    <= base_addr;
                     remaining <= num_words;
                     busy      <= 1'b1;
                     ce        <= 1'b1;
                     state     <= RD_REQ;
`ifdef ROM_DUMP_CHECKSUM_EN
                     sum       <= '0;
`endif
                  end else begin
                     done <= 1'b1;
                  end
               end
            end

            RD_REQ: state <= RD_WAIT;

            // ROM data is valid now; the start bit of byte 0 goes out on the same edge.
            RD_WAIT: begin
               word_sr  <= {data_i[23:0], 8'h00};
               tx_shift <= data_i[31:24];
`ifdef ROM_DUMP_CHECKSUM_EN
               sum      <= sum + data_i[31:24];
`endif
               byte_idx <= '0;
               bit_cnt  <= '0;
               clk_cnt  <= '0;
               uart_txd <= 1'b0;
               state    <= TX_BYTE;
            end

`ifdef ROM_DUMP_CHECKSUM_EN
            TX_BYTE, CKSUM: begin
`else
            TX_BYTE: begin
`endif
               if (clk_cnt == CNT_W'(BPS_CNT - 1)) begin
                  clk_cnt <= '0;
                  if (bit_cnt == BIT_W'(9)) begin
`ifdef ROM_DUMP_CHECKSUM_EN
                     if (state == CKSUM) state <= FINISH; else
`endif
                     if (byte_idx != 2'd3) begin
                        // Next byte starts immediately after this stop bit.
                        byte_idx <= byte_idx + 2'd1;
                        bit_cnt  <= '0;
                        uart_txd <= 1'b0;
                        tx_shift <= word_sr[31:24];
                        word_sr  <= {word_sr[23:0], 8'h00};
`ifdef ROM_DUMP_CHECKSUM_EN
                        sum      <= sum + word_sr[31:24];
`endif
                     end else begin
                        remaining <= remaining - 16'd1;
                        cur_addr  <= cur_addr + 32'd1;
                        if (remaining != 16'd1) begin
                           ce     <= 1'b1;
                           addr_o <= cur_addr + 32'd1;
                           state  <= RD_REQ;
                        end else begin
`ifdef ROM_DUMP_CHECKSUM_EN
                           tx_shift <= sum;
                           bit_cnt  <= '0;
                           uart_txd <= 1'b0;
                           state    <= CKSUM;
`else
                           state    <= FINISH;
`endif
                        end
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     if (bit_cnt == BIT_W'(8)) begin
                        uart_txd <= 1'b1;
                     end else begin
                        uart_txd <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                     end
                  end
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end

            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/rom_dump_tx.md
Name: rom_dump_tx

Overview:
- Debug readback path that dumps a range of the instruction ROM over UART.
- On a start pulse, reads num_words 32-bit words starting at base_addr through the ROM read port.
- Serialises each word as 4 bytes, MSB byte first, on uart_txd using 8N1 framing.
- Byte order matches the debug loader's assembly order, so a dumped image can be reloaded verbatim.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS clocks per bit (integer divide)

Ports:
clk  input  1  system clock
sys_rst_n  input  1  reset, asynchronous, active-low
start  input  1  single-cycle pulse; begins a dump when idle
base_addr  input  32  first ROM word address, sampled on accepted start
num_words  input  16  number of words to dump, sampled on accepted start
ce  output  1  ROM read enable, one cycle per word
addr_o  output  32  ROM word address
data_i  input  32  ROM read data, valid the cycle after ce=1
uart_txd  output  1  UART serial output, idle high
busy  output  1  high from accepted start until done
done  output  1  single-cycle pulse at end of dump

Behaviour:
- Reset is asynchronous, active-low, on clock clk: uart_txd=1, ce=0, addr_o=0, busy=0, done=0, FSM=IDLE, all counters 0.
- IDLE:
  - start=1 with num_words!=0: latch base_addr and num_words, busy=1, go to RD_REQ.
  - start=1 with num_words=0: done=1 for one cycle; busy, ce and uart_txd stay unchanged.
  - start while busy is ignored.
- RD_REQ: ce=1 and addr_o=current address for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: capture data_i into the shift word, byte index=0, go to TX_BYTE.
- TX_BYTE:
  - Transmit byte [31:24], [23:16], [15:8], [7:0] in order.
  - Frame is 10 bit periods of BPS_CNT clocks each: start bit (0), data bits LSB first, stop bit (1).
  - uart_txd is registered.
  - The next frame's start bit follows the previous stop bit with no idle gap.
- After byte 3 stop bit completes:
  - Decrement the remaining count and increment the address (32-bit wrap, 0xFFFFFFFF -> 0).
  - Remaining != 0: go to RD_REQ.
  - Remaining = 0: go to FINISH.
- FINISH: done=1 and busy=0 in the same cycle, then IDLE.
- Latency: ce=1 on the first clock after start is sampled; uart_txd falls 2 clocks after the ce cycle.
- Inter-word gap: 2 clocks of idle-high (RD_REQ, RD_WAIT) between the last stop bit of a word and the next start bit.
- Dump length: total = 1 + num_words*(40*BPS_CNT + 2) clocks from the start edge to the done pulse (without checksum).
- ce is 0 in every state other than RD_REQ; addr_o holds its last value when idle.
- Reset asserted mid-frame: uart_txd returns to 1 immediately and the dump is abandoned with no done pulse.
- data_i is ignored outside RD_WAIT.

Optional Feature:
- Macro ROM_DUMP_CHECKSUM_EN.
- Defined:
  - Maintain an 8-bit running sum (mod 256) of every data byte sent.
  - After the last word, enter CKSUM and send the sum as one extra 8N1 frame, then FINISH.
  - The sum is cleared on each accepted start.
  - Total time adds 10*BPS_CNT clocks.
- Undefined: no CKSUM state, no extra frame, no sum register.

Test Plan:
- Clocking for all scenarios: CLK_FREQ=1000000, UART_BPS=100000 (BPS_CNT=10).
- Reset, then idle 50 clocks -> uart_txd=1, ce=0, busy=0, done=0 throughout.
- base_addr=0x10, num_words=1, ROM[0x10]=0xA55A0F01, start pulse -> one ce cycle with addr_o=0x10. Expected:
  - Frames decode to 0xA5, 0x5A, 0x0F, 0x01, each bit 10 clocks.
  - done pulses at clock 403 after start.
  - busy falls with done.
- base_addr=0xFFFFFFFF, num_words=3 -> ce addresses 0xFFFFFFFF, 0x0, 0x1; 12 bytes MSB-first per word; 2-clock idle-high gap between words; single done.
- num_words=0 with start -> done pulse next cycle; ce never asserted; uart_txd stays 1; busy stays 0.
- Second start during byte 2 of a dump -> ignored, dump completes normally. Then sys_rst_n low mid-bit -> uart_txd=1 immediately, busy=0, no done.
- With ROM_DUMP_CHECKSUM_EN, repeat scenario 2 -> fifth frame 0x0F; done at clock 503 after start.
